exp5_unidade_controle: RTL and testbench

Moore control unit that sequences the exp4-style datapath (address counter, chaves register, 16x4 memory, comparator) into a one-play-per-step game.
- After iniciar, the block waits for each play on the botoes.
- It registers the play, checks the comparator, and advances the address.
- The round ends on the first mismatch (errou), on a correct last address (acertou), or when no play arrives within TIMEOUT_CYCLES (timeout).
- It replaces exp4_unidade_controle in the next top level. The datapath itself is unchanged.

---
 rtl/exp5_unidade_controle.sv | 250 +++++++++++++++++++++++++
 tb/tb_exp5_unidade_controle.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/exp5_unidade_controle.sv
// ----------------------------------------------------------------------------
// exp5_unidade_controle
//
// Moore control unit for the exp4-style game datapath (address counter,
// chaves register, 16x4 memory, comparator).
//
// The game is played one step at a time:
//   - iniciar starts a round.
//   - Each play on botoes is registered and checked against memory.
//   - On a correct play the address advances.
//   - The round ends on the first wrong play, on a correct play at the last
//     address, or when no play arrives within TIMEOUT_CYCLES cycles.
//
// Parameters:
//   TIMEOUT_CYCLES : cycles allowed in espera before timeout (>= 2)
//
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high
//   iniciar    in   start / restart a round (level)
//   botoes[3:0] in  play buttons; any bit set is a play
//   igual      in   comparator: registered chaves == memory[address]
//   fimC       in   address counter at last address
//   zeraC      out  clear address counter
//   contaC     out  increment address counter
//   zeraR      out  clear chaves register
//   registraR  out  load chaves register
//   pronto     out  round finished
//   acertou    out  round finished, all plays correct
//   errou      out  round finished on a wrong play
//   timeout    out  round finished on play timeout
//   db_estado[3:0] out  current state code (debug / hexa7seg)
//
// Handshake note: there is no valid/ready pairing here. A play is the
// rising edge of |botoes. Datapath commands are single-cycle pulses, each
// decoded from the state register, so every output is glitch-free and
// independent of the current inputs.
// ----------------------------------------------------------------------------
module exp5_unidade_controle #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] botoes,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // Width of the timeout counter. It is derived from TIMEOUT_CYCLES and
    // is never overridden.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // State codes. They double as the db_estado display value.
    localparam logic [3:0] S_INICIAL     = 4'h0;
    localparam logic [3:0] S_PREPARACAO  = 4'h1;
    localparam logic [3:0] S_ESPERA      = 4'h2;
    localparam logic [3:0] S_REGISTRA    = 4'h4;
    localparam logic [3:0] S_COMPARACAO  = 4'h5;
    localparam logic [3:0] S_PROXIMO     = 4'h6;
    localparam logic [3:0] S_FIM_ACERTOU = 4'hA;
    localparam logic [3:0] S_FIM_TIMEOUT = 4'hD;
    localparam logic [3:0] S_FIM_ERROU   = 4'hE;

    // Timer value during the last allowed espera cycle. The timer starts at
    // 0 on the first espera cycle, so this value marks the
    // TIMEOUT_CYCLES-th consecutive espera cycle.
    localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [3:0]    estado_q;
    logic [3:0]    estado_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          jogada_prev_q;
    logic          jogada;
    logic          jogada_pulse;
    logic          timer_expirou;

    // ------------------------------------------------------------------
    // Play detection.
    // A held button produces a single pulse. It must be released and
    // pressed again to count as a new play.
    // ------------------------------------------------------------------
    assign jogada        = |botoes;
    assign jogada_pulse  = jogada & ~jogada_prev_q;
    assign timer_expirou = (timer_q == TIMER_LIMIT);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        estado_d = S_INICIAL;
        case (estado_q)
            S_INICIAL: begin
                estado_d = iniciar ? S_PREPARACAO : S_INICIAL;
            end

            S_PREPARACAO: begin
                estado_d = S_ESPERA;
            end

            S_ESPERA: begin
                // A play that lands on the last allowed cycle still counts.
                if (jogada_pulse) begin
                    estado_d = S_REGISTRA;
                end else if (timer_expirou) begin
                    estado_d = S_FIM_TIMEOUT;
                end else begin
                    estado_d = S_ESPERA;
                end
            end

            S_REGISTRA: begin
                estado_d = S_COMPARACAO;
            end

            S_COMPARACAO: begin
                if (!igual) begin
                    estado_d = S_FIM_ERROU;
                end else if (fimC) begin
                    estado_d = S_FIM_ACERTOU;
                end else begin
                    estado_d = S_PROXIMO;
                end
            end

            S_PROXIMO: begin
                estado_d = S_ESPERA;
            end

            S_FIM_ACERTOU, S_FIM_ERROU, S_FIM_TIMEOUT: begin
                estado_d = iniciar ? S_PREPARACAO : estado_q;
            end

            // Unused encodings recover to inicial on the next edge.
            default: begin
                estado_d = S_INICIAL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Timer.
    // It counts only while in espera and clears everywhere else, so each
    // entry into espera starts from 0. It saturates at the limit and never
    // wraps, although espera always exits at the limit anyway.
    // ------------------------------------------------------------------
    always_comb begin
        timer_d = '0;
        if (estado_q == S_ESPERA) begin
            if (timer_expirou) begin
                timer_d = timer_q;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q      <= S_INICIAL;
            timer_q       <= '0;
            jogada_prev_q <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            timer_q       <= timer_d;
            jogada_prev_q <= jogada;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode (state register only)
    // ------------------------------------------------------------------
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = S_INICIAL;
        case (estado_q)
            S_INICIAL: begin
                db_estado = S_INICIAL;
            end

            S_PREPARACAO: begin
                zeraC     = 1'b1;
                zeraR     = 1'b1;
                db_estado = S_PREPARACAO;
            end

            S_ESPERA: begin
                db_estado = S_ESPERA;
            end

            S_REGISTRA: begin
                registraR = 1'b1;
                db_estado = S_REGISTRA;
            end

            S_COMPARACAO: begin
                db_estado = S_COMPARACAO;
            end

            S_PROXIMO: begin
                contaC    = 1'b1;
                db_estado = S_PROXIMO;
            end

            S_FIM_ACERTOU: begin
                pronto    = 1'b1;
                acertou   = 1'b1;
                db_estado = S_FIM_ACERTOU;
            end

            S_FIM_ERROU: begin
                pronto    = 1'b1;
                errou     = 1'b1;
                db_estado = S_FIM_ERROU;
            end

            S_FIM_TIMEOUT: begin
                pronto    = 1'b1;
                timeout   = 1'b1;
                db_estado = S_FIM_TIMEOUT;
            end

            // Unused encodings look exactly like inicial.
            default: begin
                db_estado = S_INICIAL;
            end
        endcase
    end

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// ----------------------------------------------------------------------------
// tb_exp5_unidade_controle
//
// Bench for exp5_unidade_controle with TIMEOUT_CYCLES = 8.
//
// Vectors give the inputs for one cycle and the state expected after the
// following edge. The expected output word is derived from that state
// code, then pushed to exp_q when the inputs are driven and popped #1
// after the edge. The address counter with fimC at address 3 is modelled
// here from the DUT's zeraC/contaC commands.
// ----------------------------------------------------------------------------
module tb_exp5_unidade_controle;

    localparam int TO = 8;

    typedef struct {
        logic [3:0] b;
        logic       ini;
        logic       ig;
        logic       rst;
        logic [3:0] st;
        byte        seg;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] botoes;
    logic       igual;
    logic       fimC;
    logic       zeraC;
    logic       contaC;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    logic [1:0]  addr;
    logic [11:0] exp_q[$];
    vec_t        vecs[$];
    int          n_checks;
    int          n_fail;
    int          n_conta;
    int          n_reg;
    byte         cur_seg;

    exp5_unidade_controle #(.TIMEOUT_CYCLES(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .botoes   (botoes),
        .igual    (igual),
        .fimC     (fimC),
        .zeraC    (zeraC),
        .contaC   (contaC),
        .zeraR    (zeraR),
        .registraR(registraR),
        .pronto   (pronto),
        .acertou  (acertou),
        .errou    (errou),
        .timeout  (timeout),
        .db_estado(db_estado)
    );

    // ---------------- clock / datapath model ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset)       addr <= 2'd0;
        else if (zeraC)  addr <= 2'd0;
        else if (contaC) addr <= addr + 2'd1;
    end
    assign fimC = (addr == 2'd3);

    // Output word {db_estado, zeraC, contaC, zeraR, registraR,
    //              pronto, acertou, errou, timeout} expected in each state.
    function automatic logic [11:0] exp_outs(input logic [3:0] st);
        logic [7:0] f;
        case (st)
            4'h1:    f = 8'b1010_0000;
            4'h4:    f = 8'b0001_0000;
            4'h6:    f = 8'b0100_0000;
            4'hA:    f = 8'b0000_1100;
            4'hE:    f = 8'b0000_1010;
            4'hD:    f = 8'b0000_1001;
            default: f = 8'b0000_0000;
        endcase
        return {st, f};
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic [3:0] b, input logic ini, input logic ig,
                        input logic rst, input logic [3:0] st, input int idx);
        logic [11:0] got;
        logic [11:0] exp;
        botoes  = b;
        iniciar = ini;
        igual   = ig;
        reset   = rst;
        exp_q.push_back(exp_outs(st));
        @(posedge clock);
        #1;
        got = {db_estado, zeraC, contaC, zeraR, registraR,
               pronto, acertou, errou, timeout};
        exp = exp_q.pop_front();
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL step_%c_%0d: got %h expected %h", cur_seg, idx, got, exp);
        end
        if (contaC === 1'b1)    n_conta++;
        if (registraR === 1'b1) n_reg++;
    endtask

    task automatic add(input logic [3:0] b, input logic ini, input logic ig,
                       input logic rst, input logic [3:0] st, input byte seg);
        vec_t v;
        v.b = b; v.ini = ini; v.ig = ig; v.rst = rst; v.st = st; v.seg = seg;
        vecs.push_back(v);
    endtask

    // One press/release play that advances the address (not the last).
    task automatic add_play_ok(input byte seg);
        add(4'h1, 1'b0, 1'b1, 1'b0, 4'h4, seg);
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h5, seg);
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h6, seg);
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, seg);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0; n_fail = 0; n_conta = 0; n_reg = 0; cur_seg = "X";
        reset = 1'b1; iniciar = 1'b0; botoes = 4'h0; igual = 1'b1;

        // Reset state.
        add(4'h0, 1'b0, 1'b1, 1'b1, 4'h0, "R");
        add(4'h0, 1'b0, 1'b1, 1'b1, 4'h0, "R");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h0, "R");

        // Full correct round over addresses 0..3.
        add(4'h0, 1'b1, 1'b1, 1'b0, 4'h1, "C");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, "C");
        for (int i = 0; i < 3; i++) add_play_ok("C");
        add(4'h1, 1'b0, 1'b1, 1'b0, 4'h4, "C");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h5, "C");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hA, "C");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hA, "C");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hA, "C");

        // Wrong second play, then restart.
        add(4'h0, 1'b1, 1'b1, 1'b0, 4'h1, "W");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, "W");
        add_play_ok("W");
        add(4'h2, 1'b0, 1'b1, 1'b0, 4'h4, "W");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h5, "W");
        add(4'h0, 1'b0, 1'b0, 1'b0, 4'hE, "W");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hE, "W");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hE, "W");
        add(4'h0, 1'b1, 1'b1, 1'b0, 4'h1, "W");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, "W");

        // Timeout: espera cycle 1 entered above; fim_timeout after cycle 8.
        for (int i = 0; i < TO - 1; i++) add(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, "T");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hD, "T");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hD, "T");
        add(4'h1, 1'b0, 1'b1, 1'b0, 4'hD, "T");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hD, "T");

        // Boundary: press on the 8th espera cycle wins over the timeout.
        // iniciar is held high meanwhile and must be ignored.
        add(4'h0, 1'b1, 1'b1, 1'b0, 4'h1, "B");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, "B");
        for (int i = 0; i < TO - 1; i++) add(4'h0, 1'b1, 1'b1, 1'b0, 4'h2, "B");
        add(4'h1, 1'b0, 1'b1, 1'b0, 4'h4, "B");
        add(4'h0, 1'b1, 1'b1, 1'b0, 4'h5, "B");
        add(4'h0, 1'b1, 1'b1, 1'b0, 4'h6, "B");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, "B");

        // Held button for 20 cycles: one play, then timeout while held.
        add(4'h8, 1'b0, 1'b1, 1'b0, 4'h4, "H");
        add(4'h8, 1'b0, 1'b1, 1'b0, 4'h5, "H");
        add(4'h8, 1'b0, 1'b1, 1'b0, 4'h6, "H");
        for (int i = 0; i < TO; i++) add(4'h8, 1'b0, 1'b1, 1'b0, 4'h2, "H");
        for (int i = 0; i < 20 - 3 - TO; i++) add(4'h8, 1'b0, 1'b1, 1'b0, 4'hD, "H");
        add(4'h0, 1'b0, 1'b1, 1'b0, 4'hD, "H");

        for (int i = 0; i < vecs.size(); i++) begin
            cur_seg = vecs[i].seg;
            step(vecs[i].b, vecs[i].ini, vecs[i].ig, vecs[i].rst, vecs[i].st, i);
        end

        // Reset mid-round with a button held across the reset.
        cur_seg = "M";
        step(4'h0, 1'b1, 1'b1, 1'b0, 4'h1, 0);
        step(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 1);
        step(4'h1, 1'b0, 1'b1, 1'b1, 4'h0, 2);
        step(4'h1, 1'b0, 1'b1, 1'b0, 4'h0, 3);
        step(4'h1, 1'b1, 1'b1, 1'b0, 4'h1, 4);
        step(4'h1, 1'b0, 1'b1, 1'b0, 4'h2, 5);
        for (int i = 0; i < 3; i++) step(4'h1, 1'b0, 1'b1, 1'b0, 4'h2, 6 + i);
        step(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 9);
        step(4'h1, 1'b0, 1'b1, 1'b0, 4'h4, 10);
        step(4'h0, 1'b0, 1'b1, 1'b0, 4'h5, 11);
        step(4'h0, 1'b0, 1'b1, 1'b0, 4'h6, 12);
        step(4'h0, 1'b0, 1'b1, 1'b0, 4'h2, 13);

        // Pulse totals: contaC 3+1+1+1+1, registraR 4+2+1+1+1.
        n_checks++;
        if (n_conta != 7) begin
            n_fail++;
            $display("FAIL contaC_total: got %0d expected %0d", n_conta, 7);
        end
        n_checks++;
        if (n_reg != 9) begin
            n_fail++;
            $display("FAIL registraR_total: got %0d expected %0d", n_reg, 9);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
